// File: rtl/stream_upsizer_if.sv
// Ready/valid bundle for the stream upsizer: narrow input beats in, packed wide words out.
// The slave modport is the upsizer's view; the master modport is the producer/consumer side.
interface stream_upsizer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic                      ready_in;
  logic                      valid_in;
  logic [IN_WIDTH-1:0]       data_in;
  logic                      last_in;
  logic                      ready_out;
  logic                      valid_out;
  logic [IN_WIDTH*RATIO-1:0] data_out;
  logic [RATIO-1:0]          keep_out;
  logic                      last_out;

  modport slave (
    output ready_in, valid_out, data_out, keep_out, last_out,
    input  valid_in, data_in, last_in, ready_out
  );

  modport master (
    input  ready_in, valid_out, data_out, keep_out, last_out,
    output valid_in, data_in, last_in, ready_out
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word; last_in flushes a partial word with a
// contiguous keep mask. The output register reloads on the draining cycle, so there is no bubble.
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input logic            clk,
  input logic            reset,
  stream_upsizer_if.slave bus
);
  localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;

  logic [IDX_W-1:0]                     r_idx;
  logic [RATIO-2:0][IN_WIDTH-1:0]       r_acc;
  logic                                 r_validOut;
  logic [RATIO-1:0][IN_WIDTH-1:0]       r_dataOut;
  logic [RATIO-1:0]                     r_keepOut;
  logic                                 r_lastOut;

  logic                                 w_completing;
  logic                                 w_slotFree;
  logic                                 w_readyIn;
  logic                                 w_accept;
  logic [RATIO-1:0][IN_WIDTH-1:0]       w_word;
  logic [RATIO-1:0]                     w_keep;

  assign w_completing = (r_idx == IDX_W'(RATIO - 1)) || bus.last_in;
  assign w_slotFree   = !r_validOut || bus.ready_out;
  // Only a completing beat needs the output slot, so partial beats flow regardless of backpressure.
  assign w_readyIn    = !reset && (w_slotFree || !w_completing);
  assign w_accept     = bus.valid_in && w_readyIn;

  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (IDX_W'(i) < r_idx) begin
        w_word[i] = r_acc[i];
      end
    end
    for (int i = 0; i < RATIO; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_word[i] = bus.data_in;
      end
      w_keep[i] = (IDX_W'(i) <= r_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_acc      <= '0;
      r_validOut <= 1'b0;
      r_dataOut  <= '0;
      r_keepOut  <= '0;
      r_lastOut  <= 1'b0;
    end else begin
      if (r_validOut && bus.ready_out) begin
        r_validOut <= 1'b0;
      end
      if (w_accept) begin
        if (w_completing) begin
          r_dataOut  <= w_word;
          r_keepOut  <= w_keep;
          r_lastOut  <= bus.last_in;
          r_validOut <= 1'b1;
          r_idx      <= '0;
          r_acc      <= '0;
        end else begin
          for (int i = 0; i < RATIO - 1; i++) begin
            if (IDX_W'(i) == r_idx) begin
              r_acc[i] <= bus.data_in;
            end
          end
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign bus.ready_in  = w_readyIn;
  assign bus.valid_out = r_validOut;
  assign bus.data_out  = r_dataOut;
  assign bus.keep_out  = r_keepOut;
  assign bus.last_out  = r_lastOut;
endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: directed scenarios plus random traffic, checked against a
// packet-level model that collects beats into a list and emits words as whole packets/chunks.
module tb_stream_upsizer;
  localparam int IN_WIDTH = 8;
  localparam int RATIO    = 4;

  typedef struct {
    logic [IN_WIDTH*RATIO-1:0] data;
    logic [RATIO-1:0]          keep;
    logic                      last;
  } word_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [IN_WIDTH-1:0] partial[$];
  word_t               expQ[$];
  word_t               outLog[$];

  stream_upsizer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

  stream_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle from the falling edge, checks outputs against the model, then advances the model
  // by what the coming rising edge should do.
  task automatic applyStimulus(input logic v, input logic [IN_WIDTH-1:0] d, input logic l,
                               input logic ro, input logic rst);
    logic  expReady;
    logic  willComplete;
    logic  accepted;
    word_t w;
    @(negedge clk);
    reset         = rst;
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.last_in   = l;
    bus.ready_out = ro;
    #1;
    willComplete = (partial.size() == RATIO - 1) || l;
    expReady     = !rst && (expQ.size() == 0 || ro || !willComplete);
    checkOutput("ready_in", 64'(bus.ready_in), 64'(expReady));
    if (rst) begin
      partial.delete();
      expQ.delete();
    end else begin
      checkOutput("valid_out", 64'(bus.valid_out), 64'(expQ.size() > 0));
      if (bus.valid_out && expQ.size() > 0) begin
        checkOutput("data_out", 64'(bus.data_out), 64'(expQ[0].data));
        checkOutput("keep_out", 64'(bus.keep_out), 64'(expQ[0].keep));
        checkOutput("last_out", 64'(bus.last_out), 64'(expQ[0].last));
      end
      if (expQ.size() > 0 && ro) begin
        w.data = bus.data_out;
        w.keep = bus.keep_out;
        w.last = bus.last_out;
        outLog.push_back(w);
        void'(expQ.pop_front());
      end
      accepted = v && expReady;
      if (accepted) begin
        partial.push_back(d);
        if (willComplete) begin
          w.data = '0;
          for (int i = 0; i < partial.size(); i++) begin
            w.data = w.data | ((IN_WIDTH*RATIO)'(partial[i]) << (IN_WIDTH * i));
          end
          w.keep = RATIO'((1 << partial.size()) - 1);
          w.last = l;
          expQ.push_back(w);
          partial.delete();
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
    word_t w;
    w = outLog[idx];
    checkOutput({tag, "_data"}, 64'(w.data), 64'(d));
    checkOutput({tag, "_keep"}, 64'(w.keep), 64'(k));
    checkOutput({tag, "_last"}, 64'(w.last), 64'(l));
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b0;

    // Reset held two cycles with valid_in high.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(bus.valid_out), 64'd0);
    checkOutput("rst_keep", 64'(bus.keep_out), 64'd0);
    checkOutput("rst_ready", 64'(bus.ready_in), 64'd1);

    // Back-to-back full words.
    base = outLog.size();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b1, 1'b0);
    idle(2);
    checkOutput("b2b_count", 64'(outLog.size() - base), 64'd2);
    checkLog("b2b0", base, 32'h44332211, 4'hF, 1'b0);
    checkLog("b2b1", base + 1, 32'h88776655, 4'hF, 1'b0);

    // Partial flush, then next beat lands in lane 0; then a single-beat packet.
    base = outLog.size();
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hB0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    idle(2);
    checkLog("flush", base, 32'h00A3A2A1, 4'h7, 1'b1);
    checkLog("lane0", base + 1, 32'h000000B0, 4'h1, 1'b1);
    checkLog("single", base + 2, 32'h000000FF, 4'h1, 1'b1);

    // Backpressure: pending word, three partial beats flow, completing beat stalls.
    base = outLog.size();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_stall", 64'(bus.ready_in), 64'd0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkLog("bp0", base, 32'h44332211, 4'hF, 1'b0);
    checkLog("bp1", base + 1, 32'h88776655, 4'hF, 1'b0);

    // Reset mid-packet discards the partial word.
    base = outLog.size();
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    idle(2);
    checkOutput("midrst_count", 64'(outLog.size() - base), 64'd1);
    checkLog("midrst", base, 32'h04030201, 4'hF, 1'b0);

    // Random traffic with backpressure, early packet ends and occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(3);
    checkOutput("final_empty", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_upsizer.md
# stream_upsizer

Single-clock ready/valid width upsizer that packs RATIO narrow input beats into one wide output word, with packet-boundary flush via `last_in`. It sits directly upstream of the write side of the clock-domain-crossing FIFO, in the FIFO's `clk_in` domain. It turns a byte-wide producer stream into wide words so the FIFO crosses fewer, wider entries. The FIFO's DATA_WIDTH is sized as IN_WIDTH*RATIO + RATIO + 1, carrying `{last_out, keep_out, data_out}`.

## Interface
- IN_WIDTH, 8, width of one input beat in bits
- RATIO, 4, input beats per output word; legal values ≥ 2
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- ready_in  output  1  block accepts the current input beat
- valid_in  input  1  input beat present
- data_in  input  IN_WIDTH  input beat
- last_in  input  1  beat is the final beat of a packet
- ready_out  input  1  consumer (FIFO write side) accepts output word
- valid_out  output  1  output word present
- data_out  output  IN_WIDTH*RATIO  packed word; first beat in lane 0 (LSBs)
- keep_out  output  RATIO  per-lane valid mask, contiguous from lane 0
- last_out  output  1  word ends a packet

## Operation
- Lane counter `idx` (0..RATIO-1) plus accumulator holding lanes 0..RATIO-2.
  - This is the only state; there is no other FSM.
- Input handshake: a beat is accepted when `valid_in && ready_in`.
- A beat is *completing* when `idx == RATIO-1 || last_in`.
- Non-completing accepted beat:
  - written into accumulator lane `idx`;
  - `idx` increments.
- Completing accepted beat loads the output register:
  - `data_out` = accumulated lanes 0..idx-1, the current beat in lane `idx`, and lanes above `idx` zero;
  - `keep_out` = (1 << (idx+1)) − 1;
  - `last_out` = `last_in`;
  - `valid_out` is set;
  - `idx` returns to 0 and the accumulator clears.
- Output slot free = `!valid_out || ready_out`.
- `ready_in` = `!reset && (slot_free || !completing)`.
  - Non-completing beats are never stalled by output backpressure.
  - `ready_in` depends combinationally on `last_in`, `idx`, `valid_out`, `ready_out` and `reset`.
  - There is no path from `valid_in` to `ready_in`.
- Output handshake: on `valid_out && ready_out` with no completing beat accepted in the same cycle, `valid_out` clears.
- Simultaneous drain and completing beat: the output register reloads and `valid_out` stays 1 (no bubble).
- While `valid_out && !ready_out`, `data_out`, `keep_out` and `last_out` hold stable.
- `last_in` on a full-word beat (`idx == RATIO-1`) gives `keep_out` all ones and `last_out` = 1.

## Timing
- Reset values (registered, after any edge with reset = 1):
  - `valid_out` = 0, `data_out` = 0, `keep_out` = 0, `last_out` = 0;
  - `idx` = 0, accumulator = 0.
- `ready_in` = 0 combinationally while `reset` = 1.
- Reset mid-packet discards partial accumulation; no partial word is emitted. A word pending in the output register is also discarded.
- Latency: a completing beat accepted at edge N gives `valid_out` = 1 in the cycle after edge N (1 cycle).
- Throughput with `ready_out` held at 1:
  - one input beat per cycle, sustained;
  - one output word per RATIO cycles;
  - `ready_in` never deasserts.
- Worst-case stall: `ready_in` is low only when a completing beat is offered while the output slot is occupied and not draining.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `valid_in` = 1 → `ready_in` = 0 throughout; `valid_out` = 0 and `keep_out` = 0 after. `ready_in` = 1 on the first cycle after reset deasserts.
- **Back-to-back full words** (IN_WIDTH = 8, RATIO = 4, `ready_out` = 1): bytes 0x11..0x88 on consecutive cycles, `last_in` = 0 →
  - `data_out` = 0x44332211, `keep_out` = 0xF, `last_out` = 0, one cycle after 0x44 is accepted;
  - then 0x88776655 four cycles later;
  - `ready_in` stays 1 throughout.
- **Partial flush:** 0xA1, 0xA2, 0xA3 with `last_in` on 0xA3 → `data_out` = 0x00A3A2A1, `keep_out` = 0x7, `last_out` = 1. The following beat 0xB0 then lands in lane 0.
- **Single-beat packet:** 0xFF with `last_in` = 1 at `idx` = 0 → `data_out` = 0x000000FF, `keep_out` = 0x1, `last_out` = 1.
- **Backpressure:** with word 0x44332211 pending and `ready_out` = 0, send 0x55, 0x66, 0x77 →
  - all three accepted;
  - 0x88 sees `ready_in` = 0 and `data_out` stays stable;
  - raise `ready_out` → 0x88 is accepted the same cycle, and 0x88776655 appears the next cycle with `valid_out` continuously 1.
- **Reset mid-packet:** accept 0xE1, 0xE2, pulse reset, then send 0x01..0x04 → only 0x04030201 (`keep_out` = 0xF) is ever output. No word containing 0xE1 appears.
